foo_rr_ctrl: RTL and testbench
==============================

// Module: foo_rr_ctrl
// PURPOSE
//  Round-robin scheduler sharing one foo datapath instance (1-bit operand in, DWIDTH result out)
//  among NREQ requesters. Non-pipelined: one operation in flight at a time.
//  Flow per operation: grant one requester, drive its operand to foo, wait the fixed foo latency,
//  capture foo's result, return it to the granted requester.
//  Sits between the requester blocks and u_foo; drives foo's i and owns the sampling of its o.
// PARAMETERS
//  DWIDTH  32  width of foo result o and of rsp_dat
//  NREQ    4   number of requesters, >=2
//  LAT     2   cycles from foo_i change to foo_o valid, 0..15 (0 = combinational foo)
// PORTS
//  clk        in   1          system clock, all logic on posedge
//  rst_n      in   1          async active-low reset
//  req        in   NREQ       per-requester request level
//  req_dat    in   NREQ       per-requester 1-bit operand, valid while its req=1
//  req_mask   in   NREQ       static config, 1 = requester enabled; masked req ignored
//  gnt        out  NREQ       one-hot grant pulse, registered
//  foo_i      out  1          operand to foo datapath, registered
//  foo_o      in   DWIDTH     result from foo datapath
//  rsp_vld    out  NREQ       one-hot response pulse to owning requester, registered
//  rsp_dat    out  DWIDTH     captured foo result, valid when |rsp_vld
//  busy       out  1          1 whenever FSM not in IDLE
// BEHAVIOUR
//  Reset: gnt=0, rsp_vld=0, rsp_dat=0, foo_i=0, busy=0, state=IDLE, ptr=0, cnt=0, owner=0.
//  Reset asserted mid-operation aborts it: no rsp_vld ever issued for the in-flight op.
//  Eligible set E = req & req_mask. Arbitration: lowest index >= ptr in E, else lowest index
//  overall (wrap). Decided combinationally in IDLE, registered on the transition edge.
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//   IDLE : if |E -> ISSUE; latch owner=winner, foo_i<=req_dat[owner], gnt[owner]<=1 for the
//          ISSUE cycle only, ptr<=(owner+1) mod NREQ, cnt<=0. Else stay, all pulses 0.
//   ISSUE: gnt=0 next. If LAT==0: rsp_dat<=foo_o, -> RESP. Else -> WAIT, cnt<=1.
//   WAIT : if cnt==LAT: rsp_dat<=foo_o, -> RESP; else cnt<=cnt+1.
//          foo_o is thus sampled at the end of the cycle exactly LAT cycles after ISSUE.
//   RESP : rsp_vld[owner]=1 for this cycle only -> IDLE.
//  foo_i held constant from ISSUE through RESP; retains last value in IDLE.
//  Handshake: requester holds req and req_dat stable until it sees gnt; drops req the cycle
//  after gnt (at latest by RESP). req still high in IDLE after RESP = new request.
//  Operand is sampled on the IDLE->ISSUE edge; later req_dat changes are ignored.
//  req dropped before grant: withdrawn, no response. req of owner dropped after grant:
//  operation still completes and responds.
//  req_mask change mid-operation affects only the next arbitration.
//  Per-op occupancy: LAT+3 cycles (ISSUE, LAT x WAIT, RESP, 1 IDLE decision cycle).
//  No starvation: any continuously eligible requester is granted within NREQ operations.
//  cnt width 4 bits; cnt never exceeds LAT.
//  Outputs gnt and rsp_vld are always zero or one-hot; never both nonzero in one cycle.
// TESTING (NREQ=4, LAT=2, DWIDTH=32, foo modeled as registered 2-stage pipe)
//  1 Reset: rst_n low 3 cycles with req=4'hF -> all outputs 0; after release gnt=4'b0001 at
//    first ISSUE.
//  2 Single req[2]=1, req_dat[2]=1 from IDLE -> gnt=4'b0100 1 cycle later, rsp_vld=4'b0100
//    exactly 4 cycles after gnt, rsp_dat = foo model output for i=1.
//  3 req=4'hF held continuously (re-asserted after each rsp) -> grant order 0,1,2,3,0;
//    spacing between gnt pulses = 5 cycles.
//  4 req=4'b1001, req_mask=4'b0111 -> only requester 0 granted; requester 3 never granted
//    or answered.
//  5 rst_n pulsed low during WAIT -> no rsp_vld; busy=0; next grant starts from ptr=0.
//  6 LAT=0 build, combinational foo -> rsp_vld 2 cycles after gnt, rsp_dat correct;
//    req dropped before grant -> no gnt.

Source files
------------

// File: rtl/foo_rr_ctrl.sv
// foo_rr_ctrl: round-robin scheduler sharing one foo datapath among NREQ requesters.
// One operation in flight at a time: grant, drive operand, wait LAT cycles,
// capture foo_o, return the result to the granted requester.
// gnt is visible during ISSUE. The response pulse is launched from RESP and is
// seen by the requester in the following (IDLE decision) cycle together with rsp_dat.
module foo_rr_ctrl #(
  parameter int DWIDTH = 32,
  parameter int NREQ   = 4,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_dat,
  input  logic [NREQ-1:0]   req_mask,
  output logic [NREQ-1:0]   gnt,
  output logic              foo_i,
  input  logic [DWIDTH-1:0] foo_o,
  output logic [NREQ-1:0]   rsp_vld,
  output logic [DWIDTH-1:0] rsp_dat,
  output logic              busy
);

  localparam int            PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
  localparam logic [3:0]    LAT_C    = 4'(LAT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        r_state;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_owner;
  logic [3:0]        r_cnt;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_rsp_vld;
  logic              r_foo_i;
  logic [DWIDTH-1:0] r_rsp_dat;

  logic [NREQ-1:0]   w_elig;
  logic              w_any;
  logic [PW-1:0]     w_win;
  logic [PW-1:0]     w_ptr_nxt;
  logic [NREQ-1:0]   w_win_oh;
  logic [NREQ-1:0]   w_owner_oh;

  // Round-robin pick: lowest eligible index at or above r_ptr, else lowest eligible overall.
  always_comb begin
    w_elig = req & req_mask;
    w_win  = '0;
    // Descending scans so the lowest matching index is the last one written.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win = PW'(i);
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_elig[i] && (PW'(i) >= r_ptr)) w_win = PW'(i);
    end
  end

  assign w_any      = |w_elig;
  assign w_ptr_nxt  = (w_win == LAST_IDX) ? '0 : w_win + 1'b1;
  assign w_win_oh   = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
  assign w_owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;

  // Control FSM: owns grant, operand, latency count, result capture and response pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_rsp_vld <= '0;
      r_foo_i   <= 1'b0;
      r_rsp_dat <= '0;
    end else begin
      r_gnt     <= '0;
      r_rsp_vld <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_ISSUE;
            r_owner <= w_win;
            r_foo_i <= req_dat[w_win];
            r_gnt   <= w_win_oh;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= '0;
          end
        end
        S_ISSUE: begin
          if (LAT == 0) begin
            // Combinational foo: result already valid in the ISSUE cycle.
            r_rsp_dat <= foo_o;
            r_state   <= S_RESP;
          end else begin
            r_cnt   <= 4'd1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == LAT_C) begin
            r_rsp_dat <= foo_o;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_RESP: begin
          r_rsp_vld <= w_owner_oh;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign rsp_vld = r_rsp_vld;
  assign rsp_dat = r_rsp_dat;
  assign foo_i   = r_foo_i;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_foo_rr_ctrl.sv
// Self-checking bench for foo_rr_ctrl: LAT=2 instance with a registered 2-stage foo,
// plus a LAT=0 instance with a combinational foo.
`timescale 1ns/1ps
module tb_foo_rr_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  req, req_dat, req_mask, gnt, rsp_vld;
  logic        foo_i, busy;
  logic [31:0] foo_o, rsp_dat, pipe1, pipe2;

  logic [3:0]  req0, req_dat0, gnt0, rsp_vld0;
  logic        foo0_i, busy0;
  logic [31:0] foo0_o, rsp_dat0;

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] dat;
  } exp_t;
  exp_t sb[$];

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  function automatic logic [31:0] foo_f(input logic b);
    return b ? 32'hA5A5_1234 : 32'h5A5A_0F0F;
  endfunction

  // foo model: two register stages
  always @(posedge clk) begin
    pipe1 <= foo_f(foo_i);
    pipe2 <= pipe1;
  end
  assign foo_o  = pipe2;
  assign foo0_o = foo_f(foo0_i);

  foo_rr_ctrl #(.DWIDTH(32), .NREQ(4), .LAT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_dat(req_dat), .req_mask(req_mask),
    .gnt(gnt), .foo_i(foo_i), .foo_o(foo_o), .rsp_vld(rsp_vld), .rsp_dat(rsp_dat),
    .busy(busy)
  );

  foo_rr_ctrl #(.DWIDTH(32), .NREQ(4), .LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .req_dat(req_dat0), .req_mask(4'hF),
    .gnt(gnt0), .foo_i(foo0_i), .foo_o(foo0_o), .rsp_vld(rsp_vld0), .rsp_dat(rsp_dat0),
    .busy(busy0)
  );

  // gnt / rsp_vld must be zero or one-hot and never overlap
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if (($countones(gnt) > 1) || ($countones(rsp_vld) > 1) || ((|gnt) && (|rsp_vld))) begin
        n_fail++;
        $display("FAIL excl: gnt=%b rsp_vld=%b (need one-hot, not both)", gnt, rsp_vld);
      end
    end
  end

  // Waits for a response pulse on the selected instance; cyc=-1 on timeout.
  task automatic wait_rsp(input bit sel, input int bound, output int cyc,
                          output logic [3:0] v, output logic [31:0] d);
    cyc = -1; v = '0; d = '0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (!sel && (|rsp_vld)) begin cyc = i; v = rsp_vld;  d = rsp_dat;  return; end
      if (sel  && (|rsp_vld0)) begin cyc = i; v = rsp_vld0; d = rsp_dat0; return; end
    end
  endtask

  task automatic test_reset();
    int cyc; logic [3:0] v; logic [31:0] d; exp_t e;
    rst_n = 1'b0; req = 4'hF; req_mask = 4'hF; req_dat = 4'h0; req0 = 4'h0; req_dat0 = 4'h0;
    repeat (3) @(negedge clk);
    n_cmp++; if (gnt !== 4'h0)      begin n_fail++; $display("FAIL rst_gnt: got %b need 0000", gnt); end
    n_cmp++; if (rsp_vld !== 4'h0)  begin n_fail++; $display("FAIL rst_rsp_vld: got %b need 0000", rsp_vld); end
    n_cmp++; if (rsp_dat !== 32'h0) begin n_fail++; $display("FAIL rst_rsp_dat: got %h need 0", rsp_dat); end
    n_cmp++; if (foo_i !== 1'b0)    begin n_fail++; $display("FAIL rst_foo_i: got %b need 0", foo_i); end
    n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %b need 0", busy); end
    rst_n = 1'b1; mon_en = 1'b1;
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0001)   begin n_fail++; $display("FAIL rst_first_gnt: got %b need 0001", gnt); end
    sb.push_back('{4'b0001, foo_f(1'b0)});
    req = 4'h0;
    wait_rsp(1'b0, 10, cyc, v, d);
    e = sb.pop_front();
    n_cmp++; if (cyc != 4)   begin n_fail++; $display("FAIL rst_rsp_lat: got %0d need 4", cyc); end
    n_cmp++; if (v !== e.vld) begin n_fail++; $display("FAIL rst_rsp_vld1: got %b need %b", v, e.vld); end
    n_cmp++; if (d !== e.dat) begin n_fail++; $display("FAIL rst_rsp_dat1: got %h need %h", d, e.dat); end
  endtask

  task automatic test_single();
    int cyc; logic [3:0] v; logic [31:0] d; exp_t e;
    req = 4'b0100; req_dat = 4'b0100;
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b need 0100", gnt); end
    n_cmp++; if (busy !== 1'b1)   begin n_fail++; $display("FAIL single_busy: got %b need 1", busy); end
    sb.push_back('{4'b0100, foo_f(1'b1)});
    req = 4'h0; req_dat = 4'h0;
    wait_rsp(1'b0, 10, cyc, v, d);
    e = sb.pop_front();
    n_cmp++; if (cyc != 4)    begin n_fail++; $display("FAIL single_lat: got %0d need 4", cyc); end
    n_cmp++; if (v !== e.vld) begin n_fail++; $display("FAIL single_vld: got %b need %b", v, e.vld); end
    n_cmp++; if (d !== e.dat) begin n_fail++; $display("FAIL single_dat: got %h need %h", d, e.dat); end
  endtask

  task automatic test_rr_order();
    int order[5] = '{0, 1, 2, 3, 0};
    int k = 0, last = 0, cyc = 0;
    logic [3:0] oh; exp_t e;
    rst_n = 1'b0; sb.delete();
    req = 4'hF; req_dat = 4'b1010; req_mask = 4'hF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    while ((k < 5 || sb.size() > 0) && cyc < 80) begin
      @(negedge clk); cyc++;
      if (|gnt) begin
        if (k < 5) begin
          oh = 4'b0001 << order[k];
          n_cmp++; if (gnt !== oh) begin n_fail++; $display("FAIL rr_gnt%0d: got %b need %b", k, gnt, oh); end
          if (k > 0) begin
            n_cmp++; if (cyc - last != 5) begin n_fail++; $display("FAIL rr_space%0d: got %0d need 5", k, cyc - last); end
          end
          last = cyc;
          sb.push_back('{oh, foo_f(req_dat[order[k]])});
          k++;
          if (k == 5) req = 4'h0;
        end else begin
          n_cmp++; n_fail++; $display("FAIL rr_extra_gnt: got %b need 0000", gnt);
        end
      end
      if (|rsp_vld) begin
        n_cmp++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL rr_rsp_unexp: got %b need none", rsp_vld); end
        else begin
          e = sb.pop_front();
          if (rsp_vld !== e.vld || rsp_dat !== e.dat) begin
            n_fail++; $display("FAIL rr_rsp: got %b/%h need %b/%h", rsp_vld, rsp_dat, e.vld, e.dat);
          end
        end
      end
    end
    n_cmp++; if (k != 5 || sb.size() != 0) begin n_fail++; $display("FAIL rr_done: got %0d grants %0d pending need 5/0", k, sb.size()); end
  endtask

  task automatic test_mask();
    int ng = 0; exp_t e;
    req = 4'b1001; req_dat = 4'b1001; req_mask = 4'b0111;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (|gnt) begin
        n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL mask_gnt: got %b need 0001", gnt); end
        sb.push_back('{4'b0001, foo_f(1'b1)}); ng++;
      end
      if (|rsp_vld) begin
        n_cmp++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL mask_rsp_unexp: got %b need none", rsp_vld); end
        else begin
          e = sb.pop_front();
          if (rsp_vld !== e.vld || rsp_dat !== e.dat) begin
            n_fail++; $display("FAIL mask_rsp: got %b/%h need %b/%h", rsp_vld, rsp_dat, e.vld, e.dat);
          end
        end
      end
      if (c == 20) req = 4'h0;
    end
    n_cmp++; if (ng < 3)         begin n_fail++; $display("FAIL mask_count: got %0d grants need >=3", ng); end
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL mask_pending: got %0d need 0", sb.size()); end
    req_mask = 4'hF;
    sb.delete();
  endtask

  task automatic test_abort();
    int cyc; logic [3:0] v; logic [31:0] d; exp_t e; bit seen = 1'b0;
    req = 4'b0010; req_dat = 4'b0010;
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL abort_gnt: got %b need 0010", gnt); end
    req = 4'h0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL abort_busy: got %b need 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (|rsp_vld) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_fail++; $display("FAIL abort_rsp: got pulse need none"); end
    req = 4'b1010; req_dat = 4'b1010;
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL abort_ptr: got %b need 0010", gnt); end
    sb.push_back('{4'b0010, foo_f(1'b1)});
    req = 4'h0;
    wait_rsp(1'b0, 10, cyc, v, d);
    e = sb.pop_front();
    n_cmp++; if (v !== e.vld || d !== e.dat) begin n_fail++; $display("FAIL abort_next_rsp: got %b/%h need %b/%h", v, d, e.vld, e.dat); end
  endtask

  task automatic test_lat0();
    int cyc; logic [3:0] v; logic [31:0] d; exp_t e; bit bad = 1'b0;
    logic [3:0] rq[2] = '{4'b1000, 4'b0010};
    logic [3:0] rd[2] = '{4'b1000, 4'b0000};
    for (int t = 0; t < 2; t++) begin
      req0 = rq[t]; req_dat0 = rd[t];
      @(negedge clk);
      n_cmp++; if (gnt0 !== rq[t]) begin n_fail++; $display("FAIL lat0_gnt%0d: got %b need %b", t, gnt0, rq[t]); end
      sb.push_back('{rq[t], foo_f(|(rd[t] & rq[t]))});
      req0 = 4'h0;
      wait_rsp(1'b1, 8, cyc, v, d);
      e = sb.pop_front();
      n_cmp++; if (cyc != 2) begin n_fail++; $display("FAIL lat0_lat%0d: got %0d need 2", t, cyc); end
      n_cmp++; if (v !== e.vld || d !== e.dat) begin n_fail++; $display("FAIL lat0_rsp%0d: got %b/%h need %b/%h", t, v, d, e.vld, e.dat); end
    end
    req0 = 4'b0001; req_dat0 = 4'b0001;
    @(negedge clk);
    n_cmp++; if (gnt0 !== 4'b0001) begin n_fail++; $display("FAIL lat0_gnt_w: got %b need 0001", gnt0); end
    sb.push_back('{4'b0001, foo_f(1'b1)});
    req0 = 4'b0100;
    @(negedge clk);
    req0 = 4'h0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (|gnt0) bad = 1'b1;
      if (|rsp_vld0) begin
        n_cmp++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL lat0_unexp: got %b need none", rsp_vld0); end
        else begin
          e = sb.pop_front();
          if (rsp_vld0 !== e.vld || rsp_dat0 !== e.dat) begin
            n_fail++; $display("FAIL lat0_rsp_w: got %b/%h need %b/%h", rsp_vld0, rsp_dat0, e.vld, e.dat);
          end
        end
      end
    end
    n_cmp++; if (bad)            begin n_fail++; $display("FAIL lat0_withdrawn: got grant need none"); end
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL lat0_pending: got %0d need 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_order();
    test_mask();
    test_abort();
    test_lat0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout need completion");
    $fatal(1, "watchdog");
  end

endmodule
